pacman_sprite_anim: RTL and testbench

Parametrised Pac-Man sprite renderer with smooth tile-to-tile motion, direction-dependent orientation and an animated three-frame mouth. Sits between the game-logic tile position (`pac_x`, `pac_y`, `dir`) and the VGA pixel mux. Asserts `pac_on` for the current scan pixel (`x`, `y`). The sprite glides toward the commanded tile at a fixed pixel rate per video frame instead of jumping a whole tile.

---
 rtl/pacman_sprite_anim.sv | 133 +++++++++++++
 tb/tb_pacman_sprite_anim.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_sprite_anim.sv
// Pac-Man sprite renderer: glides toward the commanded tile, faces dir, animates a 3-frame mouth.
// Latency: pac_on is combinational from x/y/dir; pos/mframe update on frame_tick; moving is one cycle behind pos.
// Backpressure: none; frame_tick is a free-running pulse and every scan pixel is answered immediately.
//
// Ports: clk/reset (sync, active-high), frame_tick (vblank pulse), gameover (blank + freeze),
//        x/y scan pixel, pac_x/pac_y commanded tile, dir (0 R, 1 L, 2 U, 3 D),
//        pac_on sprite pixel present, moving sprite not yet at commanded tile.
module pacman_sprite_anim #(
   parameter int TILE     = 21,
   parameter int X_OFF    = 100,
   parameter int Y_OFF    = 9,
   parameter int STEP_PX  = 3,
   parameter int ANIM_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       gameover,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [4:0] pac_x,
   input  logic [4:0] pac_y,
   input  logic [1:0] dir,
   output logic       pac_on,
   output logic       moving
);

   localparam int             C         = TILE / 2;
   localparam int             R2        = (C - 1) * (C - 1);
   localparam logic [9:0]     TILE_X    = 10'(TILE);
   localparam logic [8:0]     TILE_Y    = 9'(TILE);
   localparam logic [9:0]     STEP_X    = 10'(STEP_PX);
   localparam logic [8:0]     STEP_Y    = 9'(STEP_PX);
   localparam logic [7:0]     ANIM_LAST = 8'(ANIM_DIV - 1);

   logic [9:0] tx, pos_x, dlx, stx;
   logic [8:0] ty, pos_y, dly, sty;
   logic       x_diff, y_diff, snap;
   logic [1:0] mframe, mf_next;
   logic       mdir;            // 0 opening, 1 closing
   logic [7:0] div_cnt;

   assign tx = 10'(int'(pac_x) * TILE + X_OFF);
   assign ty = 9'(int'(pac_y) * TILE + Y_OFF);

   // Motion decision: per-axis distance, clipped step, and the snap condition
   // for diagonal moves or jumps larger than one tile (tunnel wrap).
   always_comb begin
      x_diff  = (pos_x != tx);
      y_diff  = (pos_y != ty);
      dlx     = (tx > pos_x) ? tx - pos_x : pos_x - tx;
      dly     = (ty > pos_y) ? ty - pos_y : pos_y - ty;
      stx     = (dlx < STEP_X) ? dlx : STEP_X;
      sty     = (dly < STEP_Y) ? dly : STEP_Y;
      snap    = (x_diff && y_diff) || (dlx > TILE_X) || (dly > TILE_Y);
      mf_next = mdir ? mframe - 2'd1 : mframe + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_x   <= tx;
         pos_y   <= ty;
         mframe  <= 2'd0;
         mdir    <= 1'b0;
         div_cnt <= 8'd0;
         moving  <= 1'b0;
      end else if (!gameover) begin
         moving <= x_diff || y_diff;
         if (frame_tick) begin
            if (snap) begin
               pos_x <= tx;
               pos_y <= ty;
            end else if (x_diff) begin
               pos_x <= (tx > pos_x) ? pos_x + stx : pos_x - stx;
            end else if (y_diff) begin
               pos_y <= (ty > pos_y) ? pos_y + sty : pos_y - sty;
            end

            // Mouth only chews while travelling; ping-pong 0-1-2-1-0.
            if (moving) begin
               if (div_cnt == ANIM_LAST) begin
                  div_cnt <= 8'd0;
                  mframe  <= mf_next;
                  if (mf_next == 2'd2)
                     mdir <= 1'b1;
                  else if (mf_next == 2'd0)
                     mdir <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
         end
      end
   end

   // Pixel generation. Local offsets are one bit wider than the scan
   // coordinates so a pixel left of / above the sprite wraps to a large
   // value and falls outside the box instead of aliasing into it.
   logic [10:0] lx;
   logic [9:0]  ly;
   logic        in_box, disc, wedge;
   int          c, r, dx, dy, ady;

   assign lx = {1'b0, x} - {1'b0, pos_x};
   assign ly = {1'b0, y} - {1'b0, pos_y};

   always_comb begin
      in_box = (lx < 11'(TILE)) && (ly < 10'(TILE));
      c      = int'(lx);
      r      = int'(ly);
      // Rotate/mirror into the right-facing source frame.
      case (dir)
         2'd0:    begin c = int'(lx);            r = int'(ly); end
         2'd1:    begin c = TILE - 1 - int'(lx); r = int'(ly); end
         2'd2:    begin c = TILE - 1 - int'(ly); r = int'(lx); end
         default: begin c = int'(ly);            r = int'(lx); end
      endcase
      dx    = c - C;
      dy    = r - C;
      ady   = (dy < 0) ? -dy : dy;
      disc  = (dx * dx + dy * dy) <= R2;
      wedge = 1'b0;
      if (dx > 0) begin
         case (mframe)
            2'd1:    wedge = (2 * ady) <= dx;
            2'd2:    wedge = ady <= dx;
            default: wedge = 1'b0;
         endcase
      end
      pac_on = !gameover && in_box && disc && !wedge;
   end

endmodule

// File: tb/tb_pacman_sprite_anim.sv
// Bench for pacman_sprite_anim: directed stimulus with hand-computed expectations.
// Stimulus pushes expectations into a queue; a monitor drains and compares them on each falling edge.
// No flow control on the DUT; the monitor samples whenever expectations are pending.
module tb_pacman_sprite_anim;

   logic       clk = 1'b0;
   logic       reset, frame_tick, gameover;
   logic [9:0] x;
   logic [8:0] y;
   logic [4:0] pac_x, pac_y;
   logic [1:0] dir;
   logic       pac_on, moving;

   pacman_sprite_anim #(
      .TILE(21), .X_OFF(100), .Y_OFF(9), .STEP_PX(3), .ANIM_DIV(2)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .gameover(gameover),
      .x(x), .y(y), .pac_x(pac_x), .pac_y(pac_y), .dir(dir),
      .pac_on(pac_on), .moving(moving)
   );

   always #5 clk = ~clk;

   localparam int K_PIX = 0, K_MOV = 1, K_PX = 2, K_PY = 3, K_MF = 4;

   typedef struct {
      string name;
      int    kind;
      int    exp;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic int observe(int kind);
      case (kind)
         K_PIX:   return int'(pac_on);
         K_MOV:   return int'(moving);
         K_PX:    return int'(dut.pos_x);
         K_PY:    return int'(dut.pos_y);
         default: return int'(dut.mframe);
      endcase
   endfunction

   // Monitor: compares every pending expectation away from the active edge.
   initial begin
      exp_t e;
      int   act;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = observe(e.kind);
            checks++;
            if (act != e.exp) begin
               failures++;
               $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic expect_val(input string n, input int k, input int v);
      exp_t e;
      e.name = n;
      e.kind = k;
      e.exp  = v;
      q.push_back(e);
   endtask

   // Let the monitor drain at the falling edge, return just after it.
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic probe(input int px, input int py, input int v, input string n);
      x = 10'(px);
      y = 9'(py);
      expect_val(n, K_PIX, v);
      settle();
   endtask

   int glide_px[7] = '{166, 169, 172, 175, 178, 181, 184};
   int glide_mf[7] = '{0, 1, 1, 2, 2, 1, 1};

   initial begin
      reset = 1'b1; frame_tick = 1'b0; gameover = 1'b0;
      pac_x = 5'd3; pac_y = 5'd4; dir = 2'd0; x = '0; y = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset placement at tile (3,4): corner (163,93).
      expect_val("rst_moving", K_MOV, 0);
      expect_val("rst_pos_x",  K_PX, 163);
      expect_val("rst_pos_y",  K_PY, 93);
      expect_val("rst_mframe", K_MF, 0);
      settle();
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL direct_rst_moving: got %0b", moving);
      end
      checks++;
      if (dut.pos_x !== 10'd163) begin
         failures++;
         $display("FAIL direct_rst_pos_x: got %0d", dut.pos_x);
      end
      probe(168, 103, 1, "rst_lx5");
      probe(178, 103, 1, "rst_closed_lx15");
      probe(162, 103, 0, "rst_left_of_box");
      probe(184, 103, 0, "rst_right_of_box");
      probe(163, 103, 0, "rst_lx0_outside_disc");
      probe(164, 103, 1, "rst_lx1_disc_edge");
      probe(182, 103, 1, "rst_lx19_disc_edge");
      probe(183, 103, 0, "rst_lx20_outside_disc");
      probe(173,  92, 0, "rst_above_box");
      probe(173,  94, 1, "rst_ly1_disc_edge");
      probe(173, 114, 0, "rst_below_box");

      // Glide right one tile, three pixels per tick.
      pac_x = 5'd4;
      cyc();
      expect_val("glide_moving_rise", K_MOV, 1);
      settle();
      for (int i = 0; i < 7; i++) begin
         tick();
         expect_val($sformatf("glide_pos_x_%0d", i + 1), K_PX, glide_px[i]);
         expect_val($sformatf("glide_mframe_%0d", i + 1), K_MF, glide_mf[i]);
         if (i == 6) expect_val("glide_moving_last_tick", K_MOV, 1);
         settle();
         if (i == 1) begin
            // mframe 1, corner (169,93)
            probe(184, 106, 1, "mf1_lx15_ly13");
            probe(184, 103, 0, "mf1_lx15_ly10");
         end
         if (i == 3) begin
            // mframe 2, corner (175,93)
            probe(190, 103, 0, "mf2_right_lx15_ly10");
            probe(190, 106, 0, "mf2_right_lx15_ly13");
            dir = 2'd1;
            probe(180, 103, 0, "mf2_left_lx5");
            probe(190, 103, 1, "mf2_left_lx15");
            dir = 2'd2;
            probe(185,  98, 0, "mf2_up_ly5");
            probe(185, 108, 1, "mf2_up_ly15");
            dir = 2'd3;
            probe(185, 108, 0, "mf2_down_ly15");
            probe(185,  98, 1, "mf2_down_ly5");
            dir = 2'd0;
         end
      end
      cyc();
      expect_val("glide_moving_fall", K_MOV, 0);
      expect_val("glide_pos_hold", K_PX, 184);
      settle();
      checks++;
      if (moving !== 1'b0) begin
         failures++;
         $display("FAIL direct_glide_moving_fall: got %0b", moving);
      end

      // Second glide start: mouth closes back to frame 0.
      pac_x = 5'd5;
      cyc();
      expect_val("glide2_moving", K_MOV, 1);
      settle();
      tick();
      expect_val("glide2_pos_x", K_PX, 187);
      expect_val("glide2_mframe0", K_MF, 0);
      settle();

      // Re-aim far left: snap to (0,4).
      pac_x = 5'd0;
      tick();
      expect_val("snap_left_pos_x", K_PX, 100);
      settle();
      cyc();
      expect_val("snap_left_moving_fall", K_MOV, 0);
      settle();

      // Tunnel-wrap snap from (0,4) to (27,4).
      pac_x = 5'd27;
      cyc();
      expect_val("snap_moving_rise", K_MOV, 1);
      settle();
      tick();
      expect_val("snap_pos_x", K_PX, 667);
      expect_val("snap_moving_still_set", K_MOV, 1);
      expect_val("snap_mframe", K_MF, 1);
      settle();
      checks++;
      if (dut.pos_x !== 10'd667) begin
         failures++;
         $display("FAIL direct_snap_pos_x: got %0d", dut.pos_x);
      end
      cyc();
      expect_val("snap_moving_fall", K_MOV, 0);
      settle();

      // Vertical glide down to (27,5): y target 114.
      pac_y = 5'd5;
      cyc();
      tick();
      expect_val("vert_pos_y_1", K_PY, 96);
      expect_val("vert_pos_x_hold", K_PX, 667);
      settle();
      tick();
      expect_val("vert_pos_y_2", K_PY, 99);
      expect_val("vert_mframe", K_MF, 2);
      settle();
      probe(672, 109, 1, "vert_lx5_on");
      probe(682, 109, 0, "vert_mouth_open");

      // Gameover mid-glide: blank and frozen.
      gameover = 1'b1;
      probe(672, 109, 0, "go_blank_lx5");
      probe(677, 109, 0, "go_blank_centre");
      for (int i = 0; i < 5; i++) tick();
      expect_val("go_pos_y_frozen", K_PY, 99);
      expect_val("go_pos_x_frozen", K_PX, 667);
      expect_val("go_mframe_frozen", K_MF, 2);
      expect_val("go_moving_frozen", K_MOV, 1);
      settle();
      gameover = 1'b0;
      probe(672, 109, 1, "go_release_visible");
      tick();
      expect_val("go_resume_pos_y", K_PY, 102);
      expect_val("go_resume_mframe", K_MF, 2);
      settle();

      // Reset coincident with frame_tick mid-glide.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_val("rst2_pos_y", K_PY, 114);
      expect_val("rst2_pos_x", K_PX, 667);
      expect_val("rst2_moving", K_MOV, 0);
      expect_val("rst2_mframe", K_MF, 0);
      settle();
      checks++;
      if (moving !== 1'b0 || dut.mframe !== 2'd0) begin
         failures++;
         $display("FAIL direct_rst2: moving=%0b mframe=%0d", moving, dut.mframe);
      end
      cyc();
      expect_val("rst2_moving_stays_low", K_MOV, 0);
      settle();
      probe(672, 124, 1, "rst2_lx5_on");

      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
